// File: rtl/voice_sched_pkg.sv
// Shared types and constants for the time-multiplexed voice scheduler.
// Latency: none (declarations only); backpressure: n/a.
package voice_sched_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int DEF_PHASE_W = 24;

  localparam logic WAVE_SAW = 1'b0;
  localparam logic WAVE_TRI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Triangle folds the upper half of the ramp back down; the doubling drops the MSB.
  function automatic logic [SAMPLE_W-1:0] tri_wave(input logic [SAMPLE_W-1:0] t);
    logic [SAMPLE_W-1:0] r;
    r = t[SAMPLE_W-1] ? ~t : t;
    return {r[SAMPLE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/waveform_generators.sv
// Shared sawtooth/triangle generator driven by the top byte of a phase word.
// Latency: combinational; backpressure: none.
module waveform_generators
  import voice_sched_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  phase_i,
  output logic [SAMPLE_W-1:0] saw_o,
  output logic [SAMPLE_W-1:0] tri_o
);

  logic [SAMPLE_W-1:0] top_byte;
  logic                unused_bits;

  assign top_byte = phase_i[PHASE_W-1 -: SAMPLE_W];
  assign saw_o    = enable ? top_byte : '0;
  assign tri_o    = enable ? tri_wave(top_byte) : '0;

  // Clock and reset are carried for a future pipelined generator.
  assign unused_bits = ^{clk, rst_n, phase_i[PHASE_W-SAMPLE_W-1:0]};

endmodule

// File: rtl/voice_scheduler.sv
// Round-robin voice sweep per sample_tick; mix strobed NUM_VOICES+1 cycles after the tick.
// Ticks while busy are dropped with an overrun pulse. Hard sync built when VOICE_SCHED_HARD_SYNC_EN is defined.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  parameter  int PHASE_W    = DEF_PHASE_W,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_addr,
  input  logic [PHASE_W-1:0]        cfg_freq,
  input  logic                      cfg_wave,
  input  logic                      cfg_en,
  input  logic                      cfg_phase_clr,
  input  logic                      cfg_sync,
  output logic [SAMPLE_W+IDX_W-1:0] mix_out,
  output logic                      mix_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int ACC_W = SAMPLE_W + IDX_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mix_q, mix_d;
  logic               overrun_q, overrun_d;

  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    freq_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] wave_q, en_q, sync_q;

  logic [PHASE_W:0]    step_sum;
  logic [PHASE_W-1:0]  np, new_phase;
  logic                carry, sync_hit;
  logic [SAMPLE_W-1:0] saw_s, tri_s, sample;
  logic [ACC_W-1:0]    contrib;

  assign step_sum = {1'b0, phase_q[idx_q]} + {1'b0, freq_q[idx_q]};
  assign np       = step_sum[PHASE_W-1:0];
  assign carry    = step_sum[PHASE_W];

`ifdef VOICE_SCHED_HARD_SYNC_EN
  logic wrap_q;

  assign sync_hit = en_q[idx_q] && sync_q[idx_q] && wrap_q && (idx_q != '0);

  // Frame-local: set by voice 0 carrying out, cleared when the next frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else if (state_q == ST_IDLE && sample_tick) begin
      wrap_q <= 1'b0;
    end else if (state_q == ST_RUN && idx_q == '0 && en_q[0] && carry) begin
      wrap_q <= 1'b1;
    end
  end
`else
  logic unused_sync;

  assign sync_hit    = 1'b0;
  assign unused_sync = ^{sync_q, carry};
`endif

  assign new_phase = sync_hit ? '0 : np;

  waveform_generators #(.PHASE_W(PHASE_W)) u_gen (
    .clk     (clk),
    .rst_n   (~rst),
    .enable  (1'b1),
    .phase_i (new_phase),
    .saw_o   (saw_s),
    .tri_o   (tri_s)
  );

  assign sample  = (wave_q[idx_q] == WAVE_TRI) ? tri_s : saw_s;
  assign contrib = en_q[idx_q] ? {{IDX_W{1'b0}}, sample} : '0;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mix_d     = mix_q;
    overrun_d = sample_tick && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + contrib;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          mix_d   = acc_q + contrib;
          state_d = ST_OUT;
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      mix_q     <= mix_d;
      overrun_q <= overrun_d;
    end
  end

  // A phase clear beats the same-cycle RUN advance; the sample already used the old phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_q <= '0;
      en_q   <= '0;
      sync_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        freq_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_we && cfg_addr == IDX_W'(v)) begin
          freq_q[v] <= cfg_freq;
          wave_q[v] <= cfg_wave;
          en_q[v]   <= cfg_en;
          sync_q[v] <= cfg_sync;
        end
        if (cfg_we && cfg_phase_clr && cfg_addr == IDX_W'(v)) begin
          phase_q[v] <= '0;
        end else if (state_q == ST_RUN && idx_q == IDX_W'(v) && en_q[v]) begin
          phase_q[v] <= new_phase;
        end
      end
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a frame-level reference model checked every cycle.
module tb_voice_scheduler;

  localparam int NV   = 4;
  localparam int PW   = 24;
  localparam int IW   = 2;
  localparam int PMOD = 1 << PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [PW-1:0] cfg_freq;
  logic          cfg_wave;
  logic          cfg_en;
  logic          cfg_phase_clr;
  logic          cfg_sync;
  logic [7+IW:0] mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_freq      (cfg_freq),
    .cfg_wave      (cfg_wave),
    .cfg_en        (cfg_en),
    .cfg_phase_clr (cfg_phase_clr),
    .cfg_sync      (cfg_sync),
    .mix_out       (mix_out),
    .mix_valid     (mix_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cnt_valid = 0;
  int cnt_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase [NV];
  int m_freq  [NV];
  bit m_wave  [NV];
  bit m_en    [NV];
  bit m_sync  [NV];
  int m_pos = -1;          // -1 idle, 0..NV-1 voice being swept, NV = output cycle
  int m_sum = 0;
  int m_mix = 0;
  bit m_ovr = 1'b0;
  bit m_wrap = 1'b0;
  int mp, mnp, mt;
  bit msync;

  function automatic int wave_val(input int t, input bit is_tri);
    if (!is_tri) return t;
    return (t < 128) ? 2 * t : 2 * (255 - t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        m_phase[i] = 0; m_freq[i] = 0; m_wave[i] = 0; m_en[i] = 0; m_sync[i] = 0;
      end
      m_pos = -1; m_sum = 0; m_mix = 0; m_ovr = 0; m_wrap = 0;
    end else begin
      mp    = m_pos;
      m_ovr = sample_tick && (mp != -1);
      if (mp >= 0 && mp < NV) begin
        mnp   = m_phase[mp] + m_freq[mp];
        msync = 1'b0;
`ifdef VOICE_SCHED_HARD_SYNC_EN
        if (mp > 0 && m_en[mp] && m_sync[mp] && m_wrap) msync = 1'b1;
        if (mp == 0 && m_en[0] && mnp >= PMOD) m_wrap = 1'b1;
`endif
        mnp = mnp % PMOD;
        if (m_en[mp]) begin
          m_phase[mp] = msync ? 0 : mnp;
          mt = mnp / (1 << (PW - 8));
          if (!msync) m_sum += wave_val(mt, m_wave[mp]);
        end
        if (mp == NV - 1) m_mix = m_sum;
        m_pos = mp + 1;
      end else if (mp == NV) begin
        m_pos = -1;
      end else if (sample_tick) begin
        m_pos = 0; m_sum = 0; m_wrap = 0;
      end
      if (cfg_we) begin
        m_freq[cfg_addr] = int'(cfg_freq);
        m_wave[cfg_addr] = cfg_wave;
        m_en[cfg_addr]   = cfg_en;
        m_sync[cfg_addr] = cfg_sync;
        if (cfg_phase_clr) m_phase[cfg_addr] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mix_valid) cnt_valid++;
    if (overrun) cnt_ovr++;
    if (chk_en) begin
      chk("busy", {31'd0, busy}, (m_pos != -1) ? 1 : 0);
      chk("mix_valid", {31'd0, mix_valid}, (m_pos == NV) ? 1 : 0);
      chk("overrun", {31'd0, overrun}, m_ovr ? 1 : 0);
      chk("mix_out", {22'd0, mix_out}, m_mix);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic cfg(input int a, input int f, input bit w, input bit e, input bit clr, input bit s);
    cfg_we = 1'b1; cfg_addr = IW'(a); cfg_freq = PW'(f);
    cfg_wave = w; cfg_en = e; cfg_phase_clr = clr; cfg_sync = s;
    step();
    cfg_we = 1'b0; cfg_phase_clr = 1'b0;
  endtask

  task automatic tick1();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input int exp, input string name, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (mix_valid) begin
        seen = 1'b1;
        lat  = i;
        chk(name, {22'd0, mix_out}, exp);
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int lat, v0, o0;

  initial begin
    rst = 1'b1; sample_tick = 0; cfg_we = 0; cfg_addr = 0; cfg_freq = 0;
    cfg_wave = 0; cfg_en = 0; cfg_phase_clr = 0; cfg_sync = 0;
    step();
    chk_en = 1'b1;
    chk("rst_mix_out", {22'd0, mix_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    step();

    // Empty frame after reset: strobe on the 5th cycle after the tick edge.
    tick1();
    wait_valid(0, "reset_mix", lat);
    chk("reset_latency", lat, NV + 1);

    // Sawtooth on voice 0, back-to-back frames, wraps after 256.
    do_reset();
    cfg(0, 32'h010000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 256; n++) begin
      tick1();
      wait_valid(n % 256, "saw_frame", lat);
      if (n <= 3) chk("saw_latency", lat, NV + 1);
    end

    // Triangle plus sawtooth mix.
    do_reset();
    cfg(0, 32'h400000, 1'b1, 1'b1, 1'b0, 1'b0);
    cfg(1, 32'h400000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick1(); wait_valid(192, "tri_mix_f1", lat);
    tick1(); wait_valid(382, "tri_mix_f2", lat);
    tick1(); wait_valid(318, "tri_mix_f3", lat);

    // Overrun during RUN: one pulse, single strobe.
    do_reset();
    cfg(0, 32'h010000, 1'b0, 1'b1, 1'b0, 1'b0);
    v0 = cnt_valid; o0 = cnt_ovr;
    tick1();
    step();
    tick1();
    repeat (10) step();
    chk("ovr_run_pulses", cnt_ovr - o0, 1);
    chk("ovr_run_valids", cnt_valid - v0, 1);

    // Tick in the OUT cycle also overruns.
    v0 = cnt_valid; o0 = cnt_ovr;
    tick1();
    repeat (NV) step();
    tick1();
    repeat (10) step();
    chk("ovr_out_pulses", cnt_ovr - o0, 1);
    chk("ovr_out_valids", cnt_valid - v0, 1);

    // Phase clear colliding with voice 2's own sweep step.
    do_reset();
    cfg(2, 32'h400000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick1(); wait_valid(64, "clr_f1", lat);
    tick1();
    step();
    step();
    cfg(2, 32'h400000, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_valid(128, "clr_old_phase", lat);
    tick1(); wait_valid(64, "clr_next_frame", lat);

    // Reset mid-RUN: no strobe, everything cleared.
    v0 = cnt_valid;
    tick1();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("rst_mid_valids", cnt_valid - v0, 0);
    chk("rst_mid_mix", {22'd0, mix_out}, 0);
    tick1(); wait_valid(0, "rst_mid_cfg_lost", lat);

    // Hard sync of voice 1 to voice 0.
    do_reset();
    cfg(0, 32'h800000, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(1, 32'h100000, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef VOICE_SCHED_HARD_SYNC_EN
    tick1(); wait_valid(144, "sync_f1", lat);
    tick1(); wait_valid(0,   "sync_f2", lat);
    tick1(); wait_valid(144, "sync_f3", lat);
    tick1(); wait_valid(0,   "sync_f4", lat);
`else
    tick1(); wait_valid(144, "nosync_f1", lat);
    tick1(); wait_valid(32,  "nosync_f2", lat);
    tick1(); wait_valid(176, "nosync_f3", lat);
    tick1(); wait_valid(64,  "nosync_f4", lat);
`endif

    repeat (3) step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
